// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (ALU vs long-latency unit) plus the issue-side
// RAW/WAW scoreboard that stalls decode until pending long-latency results land.
module regfile_wb_scheduler #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  output logic        stall,
  input  logic        alu_wr_en,
  input  logic [4:0]  alu_wr_reg,
  input  logic [31:0] alu_wr_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        RegisterWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeBack,
  output logic        err_orphan
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [31:0]      busy, busy_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [STV_W-1:0] starve, starve_nxt;

  logic        alu_req;
  logic        lu_hs;
  logic        accept;
  logic        orphan;
  logic        wr_en_nxt;
  logic [4:0]  wr_reg_nxt;
  logic [31:0] wr_data_nxt;

  // Arbitration and hazard detection; ALU always wins the port.
  always_comb begin
    alu_req  = alu_wr_en && (alu_wr_reg != 5'd0);
    lu_ready = !rst && !alu_req;
    lu_hs    = lu_valid && lu_ready;
    stall    = rst
            || busy[issue_rs] || busy[issue_rt]
            || busy[issue_rd]
            || (issue_long && (count == CNT_W'(MAX_OUTSTANDING)))
            || (starve == STV_W'(STARVE_LIMIT));
    accept   = issue_valid && !stall;
    orphan   = lu_hs && (count == '0);
  end

  // Write-port request selection; LU writes to $0 are swallowed.
  always_comb begin
    wr_en_nxt   = 1'b0;
    wr_reg_nxt  = writeRegister;
    wr_data_nxt = writeBack;
    if (alu_req) begin
      wr_en_nxt   = 1'b1;
      wr_reg_nxt  = alu_wr_reg;
      wr_data_nxt = alu_wr_data;
    end else if (lu_hs && (lu_reg != 5'd0)) begin
      wr_en_nxt   = 1'b1;
      wr_reg_nxt  = lu_reg;
      wr_data_nxt = lu_data;
    end
  end

  // Scoreboard, outstanding count and starvation counter next state.
  always_comb begin
    busy_nxt = busy;
    if (lu_hs) begin
      busy_nxt[lu_reg] = 1'b0;
    end
    if (accept && issue_long && (issue_rd != 5'd0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;

    count_nxt = count;
    if (accept && issue_long && !lu_hs) begin
      count_nxt = count + CNT_W'(1);
    end else if (!(accept && issue_long) && lu_hs && (count != '0)) begin
      count_nxt = count - CNT_W'(1);
    end

    starve_nxt = starve;
    if (!lu_valid || lu_hs) begin
      starve_nxt = '0;
    end else if (starve != STV_W'(STARVE_LIMIT)) begin
      starve_nxt = starve + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      count         <= '0;
      starve        <= '0;
      err_orphan    <= 1'b0;
      RegisterWrite <= 1'b0;
      writeRegister <= 5'd0;
      writeBack     <= 32'd0;
    end else begin
      busy          <= busy_nxt;
      count         <= count_nxt;
      starve        <= starve_nxt;
      err_orphan    <= err_orphan || orphan;
      RegisterWrite <= wr_en_nxt;
      writeRegister <= wr_reg_nxt;
      writeBack     <= wr_data_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, issue_rs, issue_rt;
  logic        stall;
  logic        alu_wr_en;
  logic [4:0]  alu_wr_reg;
  logic [31:0] alu_wr_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        RegisterWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeBack;
  logic        err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .stall(stall),
    .alu_wr_en(alu_wr_en), .alu_wr_reg(alu_wr_reg), .alu_wr_data(alu_wr_data),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .RegisterWrite(RegisterWrite), .writeRegister(writeRegister),
    .writeBack(writeBack), .err_orphan(err_orphan)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic v, input logic lng, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt);
    issue_valid = v; issue_long = lng; issue_rd = rd; issue_rs = rs; issue_rt = rt;
  endtask

  initial begin
    rst = 1'b1;
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    alu_wr_en = 1'b0; alu_wr_reg = 5'd0; alu_wr_data = 32'd0;
    lu_valid = 1'b0; lu_reg = 5'd0; lu_data = 32'd0;

    // Reset state
    tick(); tick();
    settle();
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_lu_ready", 32'(lu_ready), 32'd0);
    rst = 1'b0;
    tick();
    settle();
    check("rst_regwrite", 32'(RegisterWrite), 32'd0);
    check("rst_wreg", 32'(writeRegister), 32'd0);
    check("rst_wb", writeBack, 32'd0);
    check("rst_orphan", 32'(err_orphan), 32'd0);
    check("rst_stall_idle", 32'(stall), 32'd0);

    // ALU-only writes, $0 dropped
    alu_wr_en = 1'b1; alu_wr_reg = 5'd5; alu_wr_data = 32'hDEADBEEF;
    settle();
    check("alu_lu_ready", 32'(lu_ready), 32'd0);
    tick();
    alu_wr_en = 1'b0;
    settle();
    check("alu_we", 32'(RegisterWrite), 32'd1);
    check("alu_wreg", 32'(writeRegister), 32'd5);
    check("alu_wb", writeBack, 32'hDEADBEEF);
    alu_wr_en = 1'b1; alu_wr_reg = 5'd0; alu_wr_data = 32'h00001234;
    settle();
    check("alu0_lu_ready", 32'(lu_ready), 32'd1);
    tick();
    alu_wr_en = 1'b0;
    settle();
    check("alu0_we", 32'(RegisterWrite), 32'd0);
    check("alu0_wreg_hold", 32'(writeRegister), 32'd5);
    check("alu0_wb_hold", writeBack, 32'hDEADBEEF);

    // RAW on a pending long op
    issue(1'b1, 1'b1, 5'd8, 5'd1, 5'd2);
    settle();
    check("raw_issue_long", 32'(stall), 32'd0);
    tick();
    issue(1'b1, 1'b0, 5'd9, 5'd8, 5'd0);
    settle();
    check("raw_stall0", 32'(stall), 32'd1);
    tick();
    settle();
    check("raw_stall1", 32'(stall), 32'd1);
    lu_valid = 1'b1; lu_reg = 5'd8; lu_data = 32'hCAFE0008;
    settle();
    check("raw_lu_ready", 32'(lu_ready), 32'd1);
    check("raw_stall_hs", 32'(stall), 32'd1);
    tick();
    lu_valid = 1'b0;
    settle();
    check("raw_stall_after", 32'(stall), 32'd0);
    check("raw_we", 32'(RegisterWrite), 32'd1);
    check("raw_wreg", 32'(writeRegister), 32'd8);
    check("raw_wb", writeBack, 32'hCAFE0008);
    tick();
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // ALU/LU collision
    issue(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    alu_wr_en = 1'b1; alu_wr_reg = 5'd3; alu_wr_data = 32'h33;
    lu_valid = 1'b1; lu_reg = 5'd4; lu_data = 32'h44;
    settle();
    check("col_lu_ready0", 32'(lu_ready), 32'd0);
    tick();
    alu_wr_en = 1'b0;
    settle();
    check("col_alu_wreg", 32'(writeRegister), 32'd3);
    check("col_alu_wb", writeBack, 32'h33);
    check("col_lu_ready1", 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b0;
    settle();
    check("col_lu_we", 32'(RegisterWrite), 32'd1);
    check("col_lu_wreg", 32'(writeRegister), 32'd4);
    check("col_lu_wb", writeBack, 32'h44);
    tick();
    settle();
    check("col_idle_we", 32'(RegisterWrite), 32'd0);
    check("col_orphan", 32'(err_orphan), 32'd0);

    // Starvation: LU refused 8 cycles forces stall
    issue(1'b1, 1'b1, 5'd6, 5'd0, 5'd0);
    tick();
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    alu_wr_en = 1'b1; alu_wr_reg = 5'd7; alu_wr_data = 32'h77;
    lu_valid = 1'b1; lu_reg = 5'd6; lu_data = 32'h66;
    for (int i = 0; i < 8; i++) begin
      settle();
      check($sformatf("starve_pre%0d", i), 32'(stall), 32'd0);
      tick();
    end
    settle();
    check("starve_stall", 32'(stall), 32'd1);
    tick();
    settle();
    check("starve_sat", 32'(stall), 32'd1);
    alu_wr_en = 1'b0;
    settle();
    check("starve_grant", 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b0;
    settle();
    check("starve_wreg", 32'(writeRegister), 32'd6);
    check("starve_wb", writeBack, 32'h66);
    check("starve_clear", 32'(stall), 32'd0);

    // Capacity: four outstanding long ops
    for (int i = 1; i <= 4; i++) begin
      issue(1'b1, 1'b1, 5'(i), 5'd0, 5'd0);
      settle();
      check($sformatf("cap_issue%0d", i), 32'(stall), 32'd0);
      tick();
    end
    issue(1'b1, 1'b1, 5'd10, 5'd0, 5'd0);
    settle();
    check("cap_full", 32'(stall), 32'd1);
    tick();
    settle();
    check("cap_full_hold", 32'(stall), 32'd1);
    lu_valid = 1'b1; lu_reg = 5'd1; lu_data = 32'h11;
    tick();
    lu_valid = 1'b0;
    settle();
    check("cap_free", 32'(stall), 32'd0);
    tick();
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Reset mid-flight with an ALU write on the reset cycle
    rst = 1'b1;
    alu_wr_en = 1'b1; alu_wr_reg = 5'd12; alu_wr_data = 32'hAB;
    tick();
    rst = 1'b0;
    alu_wr_en = 1'b0;
    issue(1'b0, 1'b1, 5'd2, 5'd3, 5'd10);
    settle();
    check("mid_rst_we", 32'(RegisterWrite), 32'd0);
    check("mid_rst_orphan", 32'(err_orphan), 32'd0);
    check("mid_rst_busy", 32'(stall), 32'd0);
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    lu_valid = 1'b1; lu_reg = 5'd5; lu_data = 32'h55;
    settle();
    check("orph_lu_ready", 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b0;
    settle();
    check("orph_set", 32'(err_orphan), 32'd1);
    check("orph_wb", writeBack, 32'h55);
    tick();
    settle();
    check("orph_sticky", 32'(err_orphan), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
